// File: rtl/dmem_sync_bytelane_if.sv
// Request/response bundle for the byte-lane data memory.
//
// Handshake: there is no ready. A request (memread and/or memwrite, with
// address/size/sign_ext/writedata) is sampled at every rising edge and is
// always consumed in that cycle. The response appears one cycle later:
// read_valid pulses for an accepted load, and misaligned pulses for a
// rejected access. readdata is meaningful only while read_valid is high.
//
// Signals:
//   memread, memwrite   request strobes         (master -> slave)
//   address             byte address            (master -> slave)
//   size                00 byte, 01 half, 10 word, 11 reserved
//   sign_ext            load extension select   (master -> slave)
//   writedata           right-aligned store data(master -> slave)
//   readdata            extended load result    (slave -> master)
//   read_valid          load result strobe      (slave -> master)
//   misaligned          rejected-access strobe  (slave -> master)
interface dmem_sync_bytelane_if #(
  parameter int ADDR_W = 10
);
  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] address;
  logic [1:0]        size;
  logic              sign_ext;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              read_valid;
  logic              misaligned;

  modport master (
    output memread, memwrite, address, size, sign_ext, writedata,
    input  readdata, read_valid, misaligned
  );

  modport slave (
    input  memread, memwrite, address, size, sign_ext, writedata,
    output readdata, read_valid, misaligned
  );
endinterface

// File: rtl/dmem_sync_bytelane.sv
// Clocked MIPS data memory with byte/half/word access.
//
// Loads (LB/LBU/LH/LHU/LW) are extracted from the addressed word, extended
// and registered into readdata with a one-cycle read_valid pulse. Stores
// (SB/SH/SW) update only the selected byte lanes. Misaligned accesses and
// the reserved size are rejected with a one-cycle misaligned pulse.
// A load and store in the same cycle return the pre-store contents.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears outputs, not memory)
//   bus    dmem_sync_bytelane_if.slave request/response bundle
module dmem_sync_bytelane #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 10,
  parameter int INIT_Z = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dmem_sync_bytelane_if.slave    bus
);
  localparam int IDX_W = $clog2(DEPTH);

  // Storage has no reset and no power-up clear in hardware; contents
  // survive rst_n. Zero-initialisation, where wanted, belongs to the
  // simulation loader, so INIT_Z does not affect the logic here.
  logic [31:0] mem_array [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             aligned;
  logic             accept_rd;
  logic             reject;
  logic [31:0]      word_rd;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      load_val;
  logic [3:0]       byte_en;
  logic [31:0]      wr_word;

  logic [31:0] readdata_d,   readdata_q;
  logic        read_valid_d, read_valid_q;
  logic        misaligned_d, misaligned_q;

  // Address bits above the word index wrap; INIT_Z is informational.
  logic unused_ok;
  assign unused_ok = ^{bus.address[ADDR_W-1:IDX_W+2], 1'(INIT_Z)};

  always_comb begin
    idx  = bus.address[IDX_W+1:2];
    lane = bus.address[1:0];

    case (bus.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~lane[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b0;
    endcase

    accept_rd = bus.memread & aligned;
    reject    = (bus.memread | bus.memwrite) & ~aligned;

    // Old word is read combinationally, so a same-cycle store is not seen.
    word_rd = mem_array[idx];
    byte_v  = word_rd[{lane, 3'b000} +: 8];
    half_v  = lane[1] ? word_rd[31:16] : word_rd[15:0];

    case (bus.size)
      2'b00:   load_val = {{24{bus.sign_ext & byte_v[7]}}, byte_v};
      2'b01:   load_val = {{16{bus.sign_ext & half_v[15]}}, half_v};
      default: load_val = word_rd;
    endcase

    // Replicating the right-aligned store data lets each lane take its
    // own slice without shifting.
    case (bus.size)
      2'b00:   wr_word = {4{bus.writedata[7:0]}};
      2'b01:   wr_word = {2{bus.writedata[15:0]}};
      default: wr_word = bus.writedata;
    endcase

    byte_en = 4'b0000;
    if (bus.memwrite && aligned) begin
      case (bus.size)
        2'b00:   byte_en = 4'b0001 << lane;
        2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
        2'b10:   byte_en = 4'b1111;
        default: byte_en = 4'b0000;
      endcase
    end

    readdata_d   = accept_rd ? load_val : readdata_q;
    read_valid_d = accept_rd;
    misaligned_d = reject;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) mem_array[idx][8*i +: 8] <= wr_word[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata_q   <= 32'h0;
      read_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      readdata_q   <= readdata_d;
      read_valid_q <= read_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.readdata   = readdata_q;
  assign bus.read_valid = read_valid_q;
  assign bus.misaligned = misaligned_q;
endmodule

// File: tb/tb_dmem_sync_bytelane.sv
module tb_dmem_sync_bytelane;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 10;
  localparam int NBYTES = DEPTH * 4;

  logic clk;
  logic rst_n;

  dmem_sync_bytelane_if #(.ADDR_W(ADDR_W)) bus_if ();

  dmem_sync_bytelane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_Z(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  mem_m [NBYTES];
  logic [31:0] exp_q [$];
  logic [31:0] held_rd;
  int          n_assert;
  int          n_fail;

  function automatic bit ref_aligned(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (a % 2) == 0;
    if (sz == 2'd2) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sx,
                                           input logic [ADDR_W-1:0] a);
    int ba;
    logic [31:0] v;
    ba = int'(a) % NBYTES;
    if (sz == 2'd0) begin
      v = {24'h0, mem_m[ba]};
      if (sx && v[7]) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = {16'h0, mem_m[ba+1], mem_m[ba]};
      if (sx && v[15]) v = v - 32'd65536;
    end else begin
      v = {mem_m[ba+3], mem_m[ba+2], mem_m[ba+1], mem_m[ba]};
    end
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                           input logic [31:0] wd);
    int ba;
    int nb;
    ba = int'(a) % NBYTES;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < nb; i++) mem_m[ba+i] = wd[8*i +: 8];
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    bus_if.memread   = 1'b0;
    bus_if.memwrite  = 1'b0;
    bus_if.address   = '0;
    bus_if.size      = 2'b10;
    bus_if.sign_ext  = 1'b0;
    bus_if.writedata = 32'h0;
  endtask

  // Called at a negedge: drives one request, lets the edge take it, then
  // checks the registered response at the following negedge.
  task automatic op(input string tag, input bit rd, input bit wr,
                    input logic [ADDR_W-1:0] a, input logic [1:0] sz,
                    input bit sx, input logic [31:0] wd);
    bit ok;
    bit exp_rv;
    bit exp_mis;
    ok      = ref_aligned(sz, a);
    exp_rv  = rd && ok;
    exp_mis = (rd || wr) && !ok;
    if (exp_rv) exp_q.push_back(ref_load(sz, sx, a));
    if (wr && ok) ref_store(sz, a, wd);

    bus_if.memread   = rd;
    bus_if.memwrite  = wr;
    bus_if.address   = a;
    bus_if.size      = sz;
    bus_if.sign_ext  = sx;
    bus_if.writedata = wd;
    @(posedge clk);
    @(negedge clk);
    idle();

    check({tag, ".read_valid"}, {31'h0, bus_if.read_valid}, {31'h0, exp_rv});
    check({tag, ".misaligned"}, {31'h0, bus_if.misaligned}, {31'h0, exp_mis});
    if (exp_rv) begin
      if (exp_q.size() > 0) held_rd = exp_q.pop_front();
    end
    check({tag, ".readdata"}, bus_if.readdata, held_rd);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".readdata"},   bus_if.readdata,                 32'h0);
    check({tag, ".read_valid"}, {31'h0, bus_if.read_valid},      32'h0);
    check({tag, ".misaligned"}, {31'h0, bus_if.misaligned},      32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] a;
    logic [1:0]        sz;
    n_assert = 0;
    n_fail   = 0;
    held_rd  = 32'h0;
    idle();
    rst_n = 1'b0;

    // Power-up reset.
    repeat (2) @(negedge clk);
    check_cleared("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_cleared("reset_release");

    // Fill every word so later loads have defined contents.
    for (int w = 0; w < DEPTH; w++) begin
      a = ADDR_W'(w * 4);
      op("fill", 1'b0, 1'b1, a, 2'b10, 1'b0, $urandom);
    end
    check("fill_no_load_data", bus_if.readdata, 32'h0);

    // Word round trip.
    op("sw04", 1'b0, 1'b1, 10'h004, 2'b10, 1'b0, 32'hDEADBEEF);
    op("lw04", 1'b1, 1'b0, 10'h004, 2'b10, 1'b0, 32'h0);
    check("lw04_const", bus_if.readdata, 32'hDEADBEEF);
    @(negedge clk);
    check("lw04_pulse_end", {31'h0, bus_if.read_valid}, 32'h0);

    // Reset mid-operation while a read_valid pulse is pending.
    bus_if.memread = 1'b1;
    bus_if.address = 10'h004;
    bus_if.size    = 2'b10;
    @(posedge clk);
    @(negedge clk);
    idle();
    check("pre_reset_busy", bus_if.readdata, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset");
    repeat (2) @(negedge clk);
    check_cleared("reset_2cyc");
    rst_n = 1'b1;
    held_rd = 32'h0;
    repeat (2) @(negedge clk);
    check_cleared("post_reset_idle");
    op("lw04_after_rst", 1'b1, 1'b0, 10'h004, 2'b10, 1'b0, 32'h0);
    check("mem_kept_over_reset", bus_if.readdata, 32'hDEADBEEF);

    // Byte lanes and extension.
    op("sw08", 1'b0, 1'b1, 10'h008, 2'b10, 1'b0, 32'h11223344);
    op("sb09", 1'b0, 1'b1, 10'h009, 2'b00, 1'b0, 32'h000000AA);
    op("lw08", 1'b1, 1'b0, 10'h008, 2'b10, 1'b0, 32'h0);
    check("lw08_const", bus_if.readdata, 32'h1122AA44);
    op("lb09", 1'b1, 1'b0, 10'h009, 2'b00, 1'b1, 32'h0);
    check("lb09_const", bus_if.readdata, 32'hFFFFFFAA);
    op("lbu09", 1'b1, 1'b0, 10'h009, 2'b00, 1'b0, 32'h0);
    check("lbu09_const", bus_if.readdata, 32'h000000AA);
    op("lh0a", 1'b1, 1'b0, 10'h00A, 2'b01, 1'b1, 32'h0);
    check("lh0a_const", bus_if.readdata, 32'h00001122);
    op("sh0a", 1'b0, 1'b1, 10'h00A, 2'b01, 1'b0, 32'h0000C3D4);
    op("lh0a_neg", 1'b1, 1'b0, 10'h00A, 2'b01, 1'b1, 32'h0);
    check("lh0a_neg_const", bus_if.readdata, 32'hFFFFC3D4);
    op("lhu0a", 1'b1, 1'b0, 10'h00A, 2'b01, 1'b0, 32'h0);
    check("lhu0a_const", bus_if.readdata, 32'h0000C3D4);
    op("lw08_sx", 1'b1, 1'b0, 10'h008, 2'b10, 1'b1, 32'h0);
    check("lw08_sx_const", bus_if.readdata, 32'hC3D4AA44);

    // Misalignment.
    op("lw06_mis", 1'b1, 1'b0, 10'h006, 2'b10, 1'b0, 32'h0);
    check("lw06_rd_held", bus_if.readdata, 32'hC3D4AA44);
    op("sw00", 1'b0, 1'b1, 10'h000, 2'b10, 1'b0, 32'h01020304);
    op("sh03_mis", 1'b0, 1'b1, 10'h003, 2'b01, 1'b0, 32'h0000BEEF);
    op("lw00", 1'b1, 1'b0, 10'h000, 2'b10, 1'b0, 32'h0);
    check("lw00_unchanged", bus_if.readdata, 32'h01020304);
    op("size11_mis", 1'b1, 1'b1, 10'h000, 2'b11, 1'b0, 32'hFFFFFFFF);
    op("lw00_again", 1'b1, 1'b0, 10'h000, 2'b10, 1'b0, 32'h0);
    check("lw00_size11_nowrite", bus_if.readdata, 32'h01020304);

    // Same-cycle read and write.
    op("sw10", 1'b0, 1'b1, 10'h010, 2'b10, 1'b0, 32'h00000001);
    op("rw10", 1'b1, 1'b1, 10'h010, 2'b10, 1'b0, 32'h00000002);
    check("rw10_old", bus_if.readdata, 32'h00000001);
    op("lw10", 1'b1, 1'b0, 10'h010, 2'b10, 1'b0, 32'h0);
    check("lw10_new", bus_if.readdata, 32'h00000002);

    // Wrap.
    op("sw200", 1'b0, 1'b1, 10'h200, 2'b10, 1'b0, 32'h00000005);
    op("lw000_wrap", 1'b1, 1'b0, 10'h000, 2'b10, 1'b0, 32'h0);
    check("wrap_const", bus_if.readdata, 32'h00000005);

    // Streaming loads, one per cycle.
    for (int w = 0; w < DEPTH; w++) begin
      a = ADDR_W'(w * 4);
      op("stream", 1'b1, 1'b0, a, 2'b10, 1'b0, 32'h0);
    end

    // Random traffic, mostly aligned.
    for (int n = 0; n < 600; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      if ($urandom_range(0, 9) < 8) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz >= 2'd2) a[1:0] = 2'b00;
      end
      op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, sz,
         1'($urandom_range(0, 1)), $urandom);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
